online_digit_converter: RTL and testbench

Downstream companion of the radix-4 online multiply-add stage. Consumes the serial stream of signed radix-4 result digits (MSD first, digit set {-2..2}) and performs on-the-fly conversion into a conventional two's-complement word, with no carry-propagate adder. The result is presented through a valid/ready output handshake. The block sits between the online datapath and any conventional-arithmetic consumer.

---
 rtl/online_digit_converter.sv | 181 ++++++++++++++++++
 tb/tb_online_digit_converter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/online_digit_converter.sv
// online_digit_converter
// On-the-fly conversion of an MSD-first radix-4 signed-digit stream
// (digit set {-2..2}) into a two's-complement word, without any
// carry-propagate adder. Two words are kept: q_r and qm_r = q_r - 1.
// Each new digit appends two bits to one of them.
// Short frames are zero-padded to N digits. The result leaves through a
// valid/ready handshake.
// Optional feature macro: OTF_DIGIT_CHECK_EN. When it is defined, an
// invalid digit code sets a sticky error flag, reported on out_err.
module online_digit_converter #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [2:0]       in_digit,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N:0]     out_q,
  output logic             out_err
);

  localparam int DW = 2 * N + 1;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] N_C = CW'(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    PAD  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_r, state_n;
  logic [DW-1:0]   q_r, q_n, qm_r, qm_n;
  logic [CW-1:0]   cnt_r, cnt_n, cnt_inc_s;
  logic            out_valid_r;
  logic [2:0]      dig_s;
  logic [DW-1:0]   q_shift_s, qm_shift_s;

  // Map any code outside {-2..2} to digit 0 so it converts harmlessly.
  function automatic logic [2:0] sanitize(input logic [2:0] d);
    logic [2:0] r;
    case (d)
      3'b000, 3'b001, 3'b010, 3'b111, 3'b110: r = d;
      default:                                r = 3'b000;
    endcase
    return r;
  endfunction

`ifdef OTF_DIGIT_CHECK_EN
  logic err_r, err_n;

  // A code is invalid when sanitizing would change it.
  function automatic logic digit_invalid(input logic [2:0] d);
    return (sanitize(d) != d);
  endfunction
`endif

  assign cnt_inc_s = cnt_r + CW'(1);

  // Select the digit being appended: zero while padding, else the input digit.
  always_comb begin
    dig_s = 3'b000;
    if (state_r == PAD) begin
      dig_s = 3'b000;
    end else begin
      dig_s = sanitize(in_digit);
    end
  end

  // Append the digit to q_r or qm_r.
  // The low two bits are d mod 4 for q and (d-1) mod 4 for qm.
  always_comb begin
    q_shift_s  = {q_r[DW-3:0], dig_s[1:0]};
    qm_shift_s = {qm_r[DW-3:0], dig_s[1:0] - 2'd1};
    if (dig_s[2]) begin
      q_shift_s = {qm_r[DW-3:0], dig_s[1:0]};
    end else begin
      q_shift_s = {q_r[DW-3:0], dig_s[1:0]};
    end
    if (!dig_s[2] && (dig_s[1:0] != 2'd0)) begin
      qm_shift_s = {q_r[DW-3:0], dig_s[1:0] - 2'd1};
    end else begin
      qm_shift_s = {qm_r[DW-3:0], dig_s[1:0] - 2'd1};
    end
  end

  // Next-state logic: accept digits, pad short frames, and hand over the result.
  always_comb begin
    state_n = state_r;
    q_n     = q_r;
    qm_n    = qm_r;
    cnt_n   = cnt_r;
`ifdef OTF_DIGIT_CHECK_EN
    err_n   = err_r;
`endif
    case (state_r)
      IDLE, ACC: begin
        if (in_valid) begin
          q_n   = q_shift_s;
          qm_n  = qm_shift_s;
          cnt_n = cnt_inc_s;
`ifdef OTF_DIGIT_CHECK_EN
          err_n = err_r | digit_invalid(in_digit);
`endif
          if (cnt_inc_s == N_C) begin
            state_n = DONE;
          end else if (in_last) begin
            state_n = PAD;
          end else begin
            state_n = ACC;
          end
        end else begin
          state_n = state_r;
        end
      end
      PAD: begin
        q_n   = q_shift_s;
        qm_n  = qm_shift_s;
        cnt_n = cnt_inc_s;
        if (cnt_inc_s == N_C) begin
          state_n = DONE;
        end else begin
          state_n = PAD;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_n = IDLE;
          q_n     = '0;
          qm_n    = '1;
          cnt_n   = '0;
`ifdef OTF_DIGIT_CHECK_EN
          err_n   = 1'b0;
`endif
        end else begin
          state_n = DONE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and datapath registers; out_valid is registered off the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      q_r         <= '0;
      qm_r        <= '1;
      cnt_r       <= '0;
      out_valid_r <= 1'b0;
`ifdef OTF_DIGIT_CHECK_EN
      err_r       <= 1'b0;
`endif
    end else begin
      state_r     <= state_n;
      q_r         <= q_n;
      qm_r        <= qm_n;
      cnt_r       <= cnt_n;
      out_valid_r <= (state_n == DONE);
`ifdef OTF_DIGIT_CHECK_EN
      err_r       <= err_n;
`endif
    end
  end

  assign in_ready  = (state_r == IDLE) || (state_r == ACC);
  assign out_valid = out_valid_r;
  assign out_q     = q_r;
`ifdef OTF_DIGIT_CHECK_EN
  assign out_err   = err_r;
`else
  assign out_err   = 1'b0;
`endif

endmodule

// File: tb/tb_online_digit_converter.sv
// Scoreboard bench for online_digit_converter (N=8).
// Stimulus pushes the hand-computed result; a monitor pops and compares on handshake.
module tb_online_digit_converter;

  localparam int N  = 8;
  localparam int DW = 2 * N + 1;
  typedef logic [DW:0] w_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [2:0]    in_digit;
  logic          in_last;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_q;
  logic          out_err;

  int checks = 0;
  int errors = 0;
  w_t exp_q[$];
  w_t mon_exp;

`ifdef OTF_DIGIT_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  online_digit_converter #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_digit  (in_digit),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input w_t act, input w_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: compare each handed-over result against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %h, expected none", {out_err, out_q});
      end else begin
        mon_exp = exp_q.pop_front();
        chk("result", {out_err, out_q}, mon_exp);
      end
    end
  end

  task automatic send(input logic [2:0] d, input logic last);
    in_valid = 1'b1;
    in_digit = d;
    in_last  = last;
    chk("in_ready_accept", w_t'(in_ready), w_t'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Digits packed MSD first, 3 bits each; k digits sent.
  task automatic run_frame(input string name, input logic [23:0] d, input int k,
                           input logic [DW-1:0] eq, input logic ee,
                           input bit use_last, input bit hold);
    int lat;
    logic [DW-1:0] held;
    exp_q.push_back({ee, eq});
    if (hold) out_ready = 1'b0;
    for (int i = 0; i < k; i++) begin
      send(d[3*(N-1-i) +: 3], (i == k-1) && use_last);
    end
    if (k < N) begin
      in_valid = 1'b1;
      in_digit = 3'b001;
    end
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      if (k < N) chk({name, "/pad_in_ready"}, w_t'(in_ready), w_t'(0));
      if (lat > 40) begin
        checks++;
        errors++;
        $display("FAIL %s/timeout: got no out_valid, expected within 40 cycles", name);
        break;
      end
    end
    in_valid = 1'b0;
    chk({name, "/latency"}, w_t'(lat), w_t'(1 + N - k));
    if (hold) begin
      held = out_q;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        chk({name, "/hold_valid"}, w_t'(out_valid), w_t'(1));
        chk({name, "/hold_q"}, w_t'(out_q), w_t'(held));
        chk({name, "/hold_in_ready"}, w_t'(in_ready), w_t'(0));
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
    end
    @(negedge clk);
    chk({name, "/after_valid"}, w_t'(out_valid), w_t'(0));
    chk({name, "/after_in_ready"}, w_t'(in_ready), w_t'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_digit  = 3'b000;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #12;
    chk("reset_in_ready", w_t'(in_ready), w_t'(1));
    chk("reset_out_valid", w_t'(out_valid), w_t'(0));
    chk("reset_out_q", w_t'(out_q), w_t'(0));
    chk("reset_out_err", w_t'(out_err), w_t'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_frame("plus2",   24'o22222222, 8, 17'h0AAAA, 1'b0, 1'b1, 1'b0);
    run_frame("pm1",     24'o17171717, 8, 17'h03333, 1'b0, 1'b1, 1'b0);
    run_frame("minus2",  24'o66666666, 8, 17'h15556, 1'b0, 1'b0, 1'b0);
    run_frame("short",   24'o12000000, 2, 17'h06000, 1'b0, 1'b1, 1'b0);
    run_frame("hold",    24'o22222222, 8, 17'h0AAAA, 1'b0, 1'b1, 1'b1);

    // Reset in the middle of a frame discards it.
    for (int i = 0; i < 3; i++) send(3'b001, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", w_t'(out_valid), w_t'(0));
    chk("midreset_in_ready", w_t'(in_ready), w_t'(1));
    chk("midreset_out_q", w_t'(out_q), w_t'(0));
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame("ones",    24'o11111111, 8, 17'h05555, 1'b0, 1'b1, 1'b0);

    run_frame("invalid", 24'o14000000, 8, 17'h04000, ERR_EXP, 1'b1, 1'b0);
    run_frame("clean",   24'o17171717, 8, 17'h03333, 1'b0, 1'b1, 1'b0);

    @(negedge clk);
    @(negedge clk);
    chk("queue_empty", w_t'(exp_q.size()), w_t'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
